pc_redirect: RTL and testbench
==============================

PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 SHALL have parameter TRAP_VEC, 32'h0000_0100, PC value loaded on a misaligned redirect.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  load-use hold from hazard unit; freezes PC.
REQ-006 SHALL have port branch_taken  input  1  taken-branch result from branch unit, MEM stage.
REQ-007 SHALL have port jump  input  1  JAL/JALR resolved in MEM stage.
REQ-008 SHALL have port target  input  32  redirect address accompanying branch_taken/jump.
REQ-009 SHALL have port trap_ack  input  1  trap handler acknowledge.
REQ-010 SHALL have port pc  output  32  current fetch address, registered.
REQ-011 SHALL have port pc_plus4  output  32  pc + 4, combinational.
REQ-012 SHALL have port fetch_valid  output  1  instruction memory read is valid this cycle.
REQ-013 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  squash the named pipeline registers at the next edge.
REQ-014 SHALL have port trap_misalign  output  1  misaligned-target trap pending.
REQ-015 SHALL have port redirect_cnt  output  16  count of accepted redirects.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, TRAP_WAIT; encoding free.
REQ-017 BOOT SHALL last exactly one cycle after rst deasserts; pc = RESET_PC; fetch_valid=0; next state RUN.
REQ-018 redirect_req SHALL be defined as (branch_taken | jump) and be evaluated only in RUN; ignored in BOOT and TRAP_WAIT.
REQ-019 In RUN with no redirect_req and stall=0, pc SHALL advance to pc+4 at each edge; 32-bit wrap-around (32'hFFFF_FFFC -> 0) is allowed silently.
REQ-020 In RUN with stall=1 and no redirect_req, pc SHALL hold; fetch_valid remains 1.
REQ-021 In RUN with redirect_req and target[1:0]==2'b00, pc SHALL load target at the next edge regardless of stall (redirect overrides stall).
REQ-022 flush_if_id, flush_id_ex, flush_ex_mem SHALL be combinational, asserted high in the same cycle as any redirect_req evaluated in RUN, and low otherwise.
REQ-023 In RUN with redirect_req and target[1:0]!=2'b00, pc SHALL load TRAP_VEC, state SHALL go to TRAP_WAIT, trap_misalign SHALL be set at that edge; flushes asserted as REQ-022.
REQ-024 In TRAP_WAIT: pc holds TRAP_VEC, fetch_valid=0, trap_misalign=1, stall ignored; trap_ack=1 moves to RUN at the next edge, clearing trap_misalign; pc then advances per REQ-019.
REQ-025 fetch_valid SHALL be 1 exactly when state is RUN.
REQ-026 redirect_cnt SHALL increment by 1 for every redirect_req accepted in RUN (aligned or misaligned), saturating at 16'hFFFF.
REQ-027 branch_taken and jump asserted together SHALL count as one redirect using the single target.
REQ-028 pc_plus4 SHALL equal pc + 4 modulo 2^32 in every state.

Reset
REQ-029 On rst=1, immediately and without a clock: state=BOOT, pc=RESET_PC, redirect_cnt=0, trap_misalign=0, fetch_valid=0, all flushes 0.
REQ-030 Reset asserted mid-operation (any state, including TRAP_WAIT) SHALL abort it with the values of REQ-029; no pending redirect survives.

Verification
REQ-031 Release reset, no stimulus for 4 cycles -> pc sequence 0,0,4,8 (BOOT then RUN); fetch_valid 0,1,1,1.
REQ-032 In RUN at pc=8 with stall=1 for 2 cycles -> pc 8,8 then 12 after release; flushes stay 0.
REQ-033 At pc=12, branch_taken=1, target=32'h40, stall=1 in the same cycle -> all three flushes 1 that cycle; pc=32'h40 next cycle; redirect_cnt=1.
REQ-034 jump=1, target=32'h42 -> pc=32'h100, trap_misalign=1, fetch_valid=0; pc stays 32'h100 under branch_taken=1 for 3 cycles with no flushes and no count change; trap_ack=1 -> RUN, pc then 32'h104.
REQ-035 Assert rst asynchronously mid-cycle during TRAP_WAIT with redirect_cnt=5 -> pc=0, redirect_cnt=0, trap_misalign=0 before the next clock edge.
REQ-036 Force redirect_cnt to 16'hFFFF via 65535 aligned redirects, then one more -> redirect_cnt stays 16'hFFFF; pc still loads target.

Source files
------------

// File: rtl/pc_redirect.sv
// Program counter with branch/jump redirect, misaligned-target trap and
// pipeline flush generation. The redirect decision is taken from the MEM stage
// and overrides a load-use stall.
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        trap_misalign,
  output logic [15:0] redirect_cnt
);

  localparam logic [1:0] ST_BOOT      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_TRAP_WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic        redirect_req;
  logic        in_run;

  // Next-state, next-pc and counter logic; redirects are only honoured in RUN.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    trap_d       = trap_q;
    redirect_req = branch_taken | jump;
    in_run       = (state_q == ST_RUN);
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_req) begin
          // Saturate so a long-running counter never wraps back to small values.
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (target[1:0] == 2'b00) begin
            pc_d = target;
          end else begin
            pc_d    = TRAP_VEC;
            state_d = ST_TRAP_WAIT;
            trap_d  = 1'b1;
          end
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_TRAP_WAIT: begin
        // Fetch stays parked on the trap vector until the handler acknowledges.
        if (trap_ack) begin
          state_d = ST_RUN;
          trap_d  = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: recover through the boot cycle.
        state_d = ST_BOOT;
        pc_d    = RESET_PC;
        trap_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset to the boot condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign fetch_valid   = in_run;
  assign flush_if_id   = in_run & redirect_req;
  assign flush_id_ex   = in_run & redirect_req;
  assign flush_ex_mem  = in_run & redirect_req;
  assign trap_misalign = trap_q;
  assign redirect_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed and randomized bench for pc_redirect with a behavioural model.
module tb_pc_redirect;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target;
  logic        trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        trap_misalign;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b1;

  // Model: mode 0 = boot cycle, 1 = running, 2 = waiting for trap acknowledge
  int          m_mode;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_trap;

  pc_redirect #(.RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .target(target), .trap_ack(trap_ack), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .trap_misalign(trap_misalign), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0;
    m_cnt  = 0;
    m_trap = 1'b0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_step();
    bit req;
    req = branch_taken | jump;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (req) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (target % 4 == 0) m_pc = target;
        else begin
          m_pc = 32'h100; m_mode = 2; m_trap = 1'b1;
        end
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (trap_ack) begin
      m_mode = 1; m_trap = 1'b0;
    end
  endtask

  task automatic compare_all();
    bit fl;
    fl = (m_mode == 1) && (branch_taken || jump);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == 1});
    check("flushes", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, fl ? 32'd7 : 32'd0);
    check("trap_misalign", {31'd0, trap_misalign}, {31'd0, m_trap});
    check("redirect_cnt", {16'd0, redirect_cnt}, m_cnt);
  endtask

  // Called at the falling edge after inputs are driven.
  task automatic settle();
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit s, input bit b, input bit j, input logic [31:0] t, input bit a);
    stall = s; branch_taken = b; jump = j; target = t; trap_ack = a;
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    check("rst_trap", {31'd0, trap_misalign}, 32'd0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_flush", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc [3];
    logic [31:0] t;
    exp_pc = '{32'h0, 32'h0, 32'h4};
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    model_reset();
    #3;
    check("init_pc", pc, 32'h0);
    check("init_fv", {31'd0, fetch_valid}, 32'd0);
    check("init_cnt", {16'd0, redirect_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Boot then free-running fetch
    for (int i = 0; i < 3; i++) begin
      settle();
      check("boot_seq_pc", pc, exp_pc[i]);
      check("boot_seq_fv", {31'd0, fetch_valid}, (i == 0) ? 32'd0 : 32'd1);
      advance();
    end

    // Stall holds pc at 8 for two cycles
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 0, 0, 32'h0, 0);
      settle();
      check("stall_pc", pc, 32'h8);
      check("stall_fv", {31'd0, fetch_valid}, 32'd1);
      advance();
    end
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("stall_release_pc", pc, 32'hC);

    // Redirect overrides stall
    drive(1, 1, 0, 32'h40, 0);
    settle();
    check("br_flush", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'd7);
    advance();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("br_pc", pc, 32'h40);
    check("br_cnt", {16'd0, redirect_cnt}, 32'd1);

    // Misaligned jump traps; redirects ignored while waiting
    drive(0, 0, 1, 32'h42, 0);
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h80, 0);
      settle();
      check("trap_pc", pc, 32'h100);
      check("trap_flag", {31'd0, trap_misalign}, 32'd1);
      check("trap_flush", {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'd0);
      check("trap_cnt", {16'd0, redirect_cnt}, 32'd2);
      advance();
    end
    drive(0, 0, 0, 32'h0, 1);
    settle();
    advance();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("ack_fv", {31'd0, fetch_valid}, 32'd1);
    check("ack_pc", pc, 32'h100);
    advance();
    settle();
    check("ack_next_pc", pc, 32'h104);

    // Wrap-around at the top of the address space
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    settle();
    advance();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("wrap_plus4", pc_plus4, 32'h0);
    advance();
    settle();
    check("wrap_pc", pc, 32'h0);

    // Reach count 5 in trap wait, then reset asynchronously
    drive(0, 1, 0, 32'h200, 0);
    settle();
    advance();
    drive(0, 1, 1, 32'h201, 0);
    settle();
    advance();
    drive(0, 1, 0, 32'h300, 0);
    settle();
    check("pre_rst_cnt", {16'd0, redirect_cnt}, 32'd5);
    async_reset();
    drive(0, 0, 0, 32'h0, 0);

    // Saturating counter
    settle();
    advance();
    chk_en = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1, 0, {i[29:0], 2'b00}, 0);
      settle();
      advance();
    end
    chk_en = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("sat_full", {16'd0, redirect_cnt}, 32'hFFFF);
    drive(0, 0, 1, 32'h1234_5678, 0);
    settle();
    advance();
    drive(0, 0, 0, 32'h0, 0);
    settle();
    check("sat_hold", {16'd0, redirect_cnt}, 32'hFFFF);
    check("sat_pc", pc, 32'h1234_5678);
    advance();

    // Randomized traffic including mid-operation resets
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, t, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        settle();
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
